// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell (two half adders + OR) and a
// carry flop process an operand pair LSB-first, one bit per clock.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit, c_bit, h0_s, h0_c, h1_c;
  logic             last, accept;

  half_adder u_ha0 (.x(op_a[0]), .y(op_b[0]), .s(h0_s), .c(h0_c));
  half_adder u_ha1 (.x(h0_s),    .y(carry),   .s(s_bit), .c(h1_c));
  assign c_bit = h0_c | h1_c;

  // Result fills from the MSB so the LSB-first bits land in order.
  generate
    if (WIDTH == 1) begin : g_res1
      assign res_nxt = s_bit;
    end else begin : g_resn
      assign res_nxt = {s_bit, res[WIDTH-1:1]};
    end
  endgenerate

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B and seed the carry with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
      res   <= '0;
    end else if (state == SHIFT) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= c_bit;
      cnt   <= cnt + CW'(1);
      res   <= res_nxt;
      if (last) begin
        sum  <= res_nxt;
        cout <= c_bit;
        ovf  <= carry ^ c_bit;
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: WIDTH=8 and WIDTH=1 instances, hand-computed results.

module tb_serial_addsub;
  logic       clk, rst_n;
  logic       start, sub, busy, done, cout, ovf;
  logic [7:0] a, b, sum;
  logic       start1, sub1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  int vectors = 0;
  int miscompares = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_addsub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one pulse-start operation; returns just after the accepting edge.
  task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic vs);
    @(negedge clk);
    a = va; b = vb; sub = vs; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Bounded wait for done; reports busy cycles seen and any busy/done overlap.
  task automatic wait_done(output int nbusy, output bit got, output bit overlap);
    nbusy = 0; got = 0; overlap = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && done) overlap = 1;
      if (done) begin got = 1; break; end
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; sub = 0; a = 0; b = 0;
    start1 = 0; sub1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, sum, cout, ovf} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int nb; bit got, ov;
    issue(8'd100, 8'd55, 1'b0);
    wait_done(nb, got, ov);
    vectors++;
    if (!got || nb != 8 || ov) begin
      miscompares++;
      $display("FAIL add1_timing got done=%b busy_cycles=%0d overlap=%b want 1 8 0", got, nb, ov);
    end
    vectors++;
    if ({sum, cout, ovf} !== {8'd155, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL add1_result got sum=%0d cout=%b ovf=%b want 155 0 1", sum, cout, ovf);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL add1_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
    issue(8'd200, 8'd100, 1'b0);
    wait_done(nb, got, ov);
    vectors++;
    if (!got || {sum, cout, ovf} !== {8'd44, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL add2_result got done=%b sum=%0d cout=%b ovf=%b want 1 44 1 0", got, sum, cout, ovf);
    end
  endtask

  task automatic test_sub;
    int nb; bit got, ov;
    issue(8'd5, 8'd7, 1'b1);
    wait_done(nb, got, ov);
    vectors++;
    if (!got || {sum, cout, ovf} !== {8'hFE, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL sub1_result got done=%b sum=%h cout=%b ovf=%b want 1 fe 0 0", got, sum, cout, ovf);
    end
    issue(8'h80, 8'h01, 1'b1);
    @(negedge clk);
    vectors++;
    if (sum !== 8'hFE || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sub2_hold_while_busy got sum=%h busy=%b want fe 1", sum, busy);
    end
    wait_done(nb, got, ov);
    vectors++;
    if (!got || nb != 7 || {sum, cout, ovf} !== {8'h7F, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL sub2_result got done=%b busy_rest=%0d sum=%h cout=%b ovf=%b want 1 7 7f 1 1",
               got, nb, sum, cout, ovf);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] oa [3] = '{8'd10, 8'hF0, 8'h7F};
    logic [7:0] ob [3] = '{8'd20, 8'h20, 8'h01};
    logic       os [3] = '{1'b0, 1'b1, 1'b0};
    logic [9:0] exp [3] = '{{8'd30, 2'b00}, {8'hD0, 2'b10}, {8'h80, 2'b01}};
    int nb; bit got;
    @(negedge clk);
    a = oa[0]; b = ob[0]; sub = os[0]; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      nb = 0; got = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) begin got = 1; break; end
        if (busy) nb++;
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      end
      vectors++;
      if (!got || nb != 8 || {sum, cout, ovf} !== exp[k]) begin
        miscompares++;
        $display("FAIL b2b_op%0d got done=%b busy_cycles=%0d sum=%h cout=%b ovf=%b want 1 8 %h %b %b",
                 k, got, nb, sum, cout, ovf, exp[k][9:2], exp[k][1], exp[k][0]);
      end
      if (k < 2) begin a = oa[k+1]; b = ob[k+1]; sub = os[k+1]; end
      else start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle_after got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mid_reset;
    int nb; bit got, ov, saw_done;
    issue(8'hFF, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, sum, cout, ovf} !== 12'h0) begin
      miscompares++;
      $display("FAIL async_reset got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    end
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL reset_discard got done pulse=1 want 0");
    end
    issue(8'd3, 8'd4, 1'b0);
    wait_done(nb, got, ov);
    vectors++;
    if (!got || nb != 8 || sum !== 8'd7) begin
      miscompares++;
      $display("FAIL post_reset_op got done=%b busy_cycles=%0d sum=%0d want 1 8 7", got, nb, sum);
    end
  endtask

  task automatic test_width1;
    // 1 + 1 in one bit: -1 + -1 overflows, carry in 0 and carry out 1.
    logic os [2] = '{1'b0, 1'b1};
    logic [2:0] exp [2] = '{3'b011, 3'b010};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; sub1 = os[k]; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        miscompares++;
        $display("FAIL w1_op%0d_shift got busy=%b done=%b want 1 0", k, busy1, done1);
      end
      @(negedge clk);
      vectors++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || {sum1, cout1, ovf1} !== exp[k]) begin
        miscompares++;
        $display("FAIL w1_op%0d_result got done=%b busy=%b sum=%b cout=%b ovf=%b want 1 0 %b %b %b",
                 k, done1, busy1, sum1, cout1, ovf1, exp[k][2], exp[k][1], exp[k][0]);
      end
      @(negedge clk);
      vectors++;
      if (done1 !== 1'b0) begin
        miscompares++;
        $display("FAIL w1_op%0d_pulse got done=%b want 0", k, done1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_back_to_back;
    test_mid_reset;
    test_width1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
